// File: rtl/ctrl_pipe.sv
// RV32I control-word decoder with ID->EX->WB control pipeline, load-use stall
// and branch/jump redirect generation.
module ctrl_pipe #(
  parameter bit          HAZARD_EN = 1'b1,
  parameter logic [15:0] BUBBLE    = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_id,
  input  logic        stall_ext,
  input  logic        br_taken,
  output logic [15:0] hex_ex,
  output logic [4:0]  rd_ex,
  output logic [15:0] hex_wb,
  output logic [4:0]  rd_wb,
  output logic        stall_id,
  output logic        redirect,
  output logic        illegal_id
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  localparam logic [1:0] WB_MEM = 2'd0;
  localparam logic [1:0] WB_ALU = 2'd1;
  localparam logic [1:0] WB_PC4 = 2'd2;

  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_ALU   = 2'd1;
  localparam logic [1:0] PC_BR    = 2'd2;

  // Packs fields into {PCSel, WBSel, MemRW, ALUSel, BSel, ASel, BrLUn, ImmSel, RegWEn}.
  function automatic logic [15:0] mk_word(
    input logic       regw,
    input logic [2:0] imm,
    input logic       brlun,
    input logic       asel,
    input logic       bsel,
    input logic [3:0] alu,
    input logic       memrw,
    input logic [1:0] wb,
    input logic [1:0] pc
  );
    return {pc, wb, memrw, alu, bsel, asel, brlun, imm, regw};
  endfunction

  // funct7[5] selects SUB only for register-register ops; SRA/SRAI use it in both.
  function automatic logic [3:0] alu_sel(
    input logic [2:0] f3,
    input logic       alt,
    input logic       is_op
  );
    case (f3)
      3'd0:    return (is_op && alt) ? ALU_SUB : ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return alt ? ALU_SRA : ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        alt;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        unused_inst;
  logic [15:0] dec_word;
  logic        dec_illegal;
  logic        use_rs1;
  logic        use_rs2;
  logic        load_ex;
  logic        hazard;

  assign opcode      = inst_id[6:0];
  assign rd          = inst_id[11:7];
  assign funct3      = inst_id[14:12];
  assign rs1         = inst_id[19:15];
  assign rs2         = inst_id[24:20];
  assign alt         = inst_id[30];
  assign unused_inst = ^{inst_id[31], inst_id[29:25]};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    dec_word    = BUBBLE;
    dec_illegal = 1'b0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    case (opcode)
      OPC_LUI:    dec_word = mk_word(1'b1, IMM_U, 1'b0, 1'b0, 1'b1, ALU_PASSB, 1'b0, WB_ALU, PC_PLUS4);
      OPC_AUIPC:  dec_word = mk_word(1'b1, IMM_U, 1'b0, 1'b1, 1'b1, ALU_ADD, 1'b0, WB_ALU, PC_PLUS4);
      OPC_JAL:    dec_word = mk_word(1'b1, IMM_J, 1'b0, 1'b1, 1'b1, ALU_ADD, 1'b0, WB_PC4, PC_ALU);
      OPC_JALR: begin
        dec_word = mk_word(1'b1, IMM_I, 1'b0, 1'b0, 1'b1, ALU_ADD, 1'b0, WB_PC4, PC_ALU);
        use_rs1  = 1'b1;
      end
      OPC_BRANCH: begin
        dec_word = mk_word(1'b0, IMM_B, funct3[2] & funct3[1], 1'b1, 1'b1, ALU_ADD, 1'b0,
                           WB_MEM, PC_BR);
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OPC_LOAD: begin
        dec_word = mk_word(1'b1, IMM_I, funct3[2], 1'b0, 1'b1, ALU_ADD, 1'b0, WB_MEM, PC_PLUS4);
        use_rs1  = 1'b1;
      end
      OPC_STORE: begin
        dec_word = mk_word(1'b0, IMM_S, 1'b0, 1'b0, 1'b1, ALU_ADD, 1'b1, WB_MEM, PC_PLUS4);
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      OPC_OPIMM: begin
        dec_word = mk_word(1'b1, IMM_I, 1'b0, 1'b0, 1'b1, alu_sel(funct3, alt, 1'b0), 1'b0,
                           WB_ALU, PC_PLUS4);
        use_rs1  = 1'b1;
      end
      OPC_OP: begin
        dec_word = mk_word(1'b1, IMM_I, 1'b0, 1'b0, 1'b0, alu_sel(funct3, alt, 1'b1), 1'b0,
                           WB_ALU, PC_PLUS4);
        use_rs1  = 1'b1;
        use_rs2  = 1'b1;
      end
      default:    dec_illegal = 1'b1;
    endcase
  end

  assign illegal_id = dec_illegal;
  assign redirect   = (hex_ex[15:14] == PC_ALU) | ((hex_ex[15:14] == PC_BR) & br_taken);

  // A load is the only writer whose result is not ready at the end of EX.
  assign load_ex = hex_ex[0] & (hex_ex[13:12] == WB_MEM);
  assign hazard  = HAZARD_EN && load_ex && (rd_ex != 5'd0) &&
                   ((use_rs1 && (rs1 == rd_ex)) || (use_rs2 && (rs2 == rd_ex)));
  assign stall_id = hazard & ~redirect;

  // NOTE: pipeline state uses non-blocking assignments so both stages sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hex_ex <= BUBBLE;
      rd_ex  <= 5'd0;
      hex_wb <= BUBBLE;
      rd_wb  <= 5'd0;
    end else if (!stall_ext) begin
      if (redirect || stall_id || dec_illegal) begin
        hex_ex <= BUBBLE;
        rd_ex  <= 5'd0;
      end else begin
        hex_ex <= dec_word;
        rd_ex  <= rd;
      end
      hex_wb <= hex_ex;
      rd_wb  <= rd_ex;
    end
  end

endmodule
